// File: rtl/c499_key_loader_if.sv
// c499_key_loader_if: serial key load bus between a key source and the c499 key loader
interface c499_key_loader_if #(parameter int KEY_W = 37);
  logic             load_start;
  logic             load_abort;
  logic             key_sin;
  logic             key_sin_valid;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             load_busy;
  logic             load_err;
  logic             locked_out;
  modport master (
    output load_start, load_abort, key_sin, key_sin_valid,
    input  key_out, key_valid, load_busy, load_err, locked_out
  );
  modport slave (
    input  load_start, load_abort, key_sin, key_sin_valid,
    output key_out, key_valid, load_busy, load_err, locked_out
  );
endinterface

// File: rtl/c499_key_loader.sv
// c499_key_loader: serial MSB-first key loader with even-parity check; define C499_KEY_LOCKOUT_EN for lockout after three consecutive failures
module c499_key_loader #(
  parameter int KEY_W = 37,
  parameter int CNT_W = 6
) (
  input logic              clk,
  input logic              rst_n,
  c499_key_loader_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, SHIFT, PARITY
`ifdef C499_KEY_LOCKOUT_EN
    , LOCKED
`endif
  } state_t;
  state_t           state;
  logic [KEY_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             load_busy;
  logic             load_err;
`ifdef C499_KEY_LOCKOUT_EN
  logic [1:0]       fail_cnt;
  logic             locked_out;
  assign bus.locked_out = locked_out;
`else
  assign bus.locked_out = 1'b0;
`endif
  assign bus.key_out   = key_out;
  assign bus.key_valid = key_valid;
  assign bus.load_busy = load_busy;
  assign bus.load_err  = load_err;
  // Load FSM: key_out only ever takes the shift register on a parity-clean commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_busy <= 1'b0;
      load_err  <= 1'b0;
`ifdef C499_KEY_LOCKOUT_EN
      fail_cnt   <= 2'd0;
      locked_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.load_start) begin
          state     <= SHIFT;
          shreg     <= '0;
          cnt       <= '0;
          key_out   <= '0;
          key_valid <= 1'b0;
          load_err  <= 1'b0;
          load_busy <= 1'b1;
        end
        SHIFT, PARITY: if (bus.load_abort) begin
          state     <= IDLE;
          shreg     <= '0;
          cnt       <= '0;
          key_out   <= '0;
          key_valid <= 1'b0;
          load_busy <= 1'b0;
        end else if (bus.key_sin_valid) begin
          if (state == SHIFT) begin
            shreg <= {shreg[KEY_W-2:0], bus.key_sin};
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_W'(KEY_W - 1)) state <= PARITY;
          end else begin
            state     <= IDLE;
            cnt       <= '0;
            load_busy <= 1'b0;
            if (!(^{shreg, bus.key_sin})) begin
              key_out   <= shreg;
              key_valid <= 1'b1;
`ifdef C499_KEY_LOCKOUT_EN
              fail_cnt  <= 2'd0;
`endif
            end else begin
              load_err <= 1'b1;
`ifdef C499_KEY_LOCKOUT_EN
              fail_cnt <= fail_cnt + 2'd1;
              if (fail_cnt == 2'd2) begin
                state      <= LOCKED;
                locked_out <= 1'b1;
              end
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_c499_key_loader.sv
// tb_c499_key_loader: directed self-checking bench for the c499 serial key loader
module tb_c499_key_loader;
  localparam int KEY_W = 37;
  localparam logic [KEY_W-1:0] KEY_A = 37'h0_1234_5678;
  localparam logic [KEY_W-1:0] KEY_F = 37'h1F_FFFF_FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  c499_key_loader_if #(.KEY_W(KEY_W)) bus ();
  c499_key_loader #(.KEY_W(KEY_W), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic check_all(input string tag, input logic [KEY_W-1:0] k, input logic v,
                           input logic b, input logic e, input logic l);
    check({tag, ".key_out"}, 64'(bus.key_out), 64'(k));
    check({tag, ".key_valid"}, 64'(bus.key_valid), 64'(v));
    check({tag, ".load_busy"}, 64'(bus.load_busy), 64'(b));
    check({tag, ".load_err"}, 64'(bus.load_err), 64'(e));
    check({tag, ".locked_out"}, 64'(bus.locked_out), 64'(l));
  endtask
  task automatic beat(input logic b);
    bus.key_sin = b;
    bus.key_sin_valid = 1'b1;
    cyc();
    bus.key_sin_valid = 1'b0;
    bus.key_sin = 1'b0;
  endtask
  task automatic start();
    bus.load_start = 1'b1;
    cyc();
    bus.load_start = 1'b0;
  endtask
  task automatic send_bits(input logic [KEY_W-1:0] k, input int gaps);
    for (int i = KEY_W - 1; i >= 0; i--) begin
      beat(k[i]);
      if (gaps != 0) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          bus.load_start = (i % 3 == 0);
          cyc();
          bus.load_start = 1'b0;
        end
      end
    end
  endtask
  task automatic load(input logic [KEY_W-1:0] k, input logic p, input int gaps);
    start();
    send_bits(k, gaps);
    beat(p);
  endtask
  initial begin
    bus.load_start = 1'b0;
    bus.load_abort = 1'b0;
    bus.key_sin = 1'b0;
    bus.key_sin_valid = 1'b0;
    repeat (3) cyc();
    check_all("in_reset", '0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (10) cyc();
    check_all("idle", '0, 0, 0, 0, 0);
    start();
    check("start.busy", 64'(bus.load_busy), 64'd1);
    send_bits(KEY_A, 0);
    check_all("pre_parity", '0, 0, 1, 0, 0);
    beat(1'b1);
    check_all("good_a", KEY_A, 1, 0, 0, 0);
    load(KEY_A, 1'b0, 0);
    check_all("bad_a", '0, 0, 0, 1, 0);
    start();
    check_all("restart_clears_err", '0, 0, 1, 0, 0);
    send_bits(KEY_A, 0);
    beat(1'b1);
    check_all("good_after_bad", KEY_A, 1, 0, 0, 0);
    start();
    for (int i = 0; i < 20; i++) beat(i[0]);
    bus.load_abort = 1'b1;
    bus.key_sin_valid = 1'b1;
    cyc();
    bus.load_abort = 1'b0;
    bus.key_sin_valid = 1'b0;
    check_all("abort", '0, 0, 0, 0, 0);
    load(KEY_F, 1'b1, 0);
    check_all("good_f", KEY_F, 1, 0, 0, 0);
    load(KEY_A, 1'b1, 1);
    check_all("gapped_a", KEY_A, 1, 0, 0, 0);
    bus.load_start = 1'b1;
    bus.load_abort = 1'b1;
    cyc();
    bus.load_start = 1'b0;
    bus.load_abort = 1'b0;
    check_all("start_abort_idle", '0, 0, 1, 0, 0);
    send_bits(KEY_F, 0);
    bus.load_abort = 1'b1;
    cyc();
    bus.load_abort = 1'b0;
    check_all("abort_in_parity", '0, 0, 0, 0, 0);
    repeat (3) load(KEY_A, 1'b0, 0);
`ifdef C499_KEY_LOCKOUT_EN
    check_all("third_fail", '0, 0, 0, 1, 1);
    start();
    check_all("locked_start", '0, 0, 0, 1, 1);
    send_bits(KEY_A, 0);
    beat(1'b1);
    check_all("locked_load", '0, 0, 0, 1, 1);
    rst_n = 1'b0;
    cyc();
    check_all("reset_clears", '0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc();
    load(KEY_A, 1'b1, 0);
    check_all("post_reset_load", KEY_A, 1, 0, 0, 0);
`else
    check_all("third_fail", '0, 0, 0, 1, 0);
    load(KEY_A, 1'b1, 0);
    check_all("fourth_load", KEY_A, 1, 0, 0, 0);
    start();
    for (int i = 0; i < 10; i++) beat(1'b1);
    rst_n = 1'b0;
    cyc();
    check_all("reset_mid_load", '0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/c499_key_loader.md
# c499_key_loader

Serial key loader that sits directly upstream of the locked c499 single-error-correcting core. It receives the 37-bit unlock key (4 mux-select bits plus 33 XOR key bits) over a one-bit serial interface and checks it against an even-parity bit. It presents the key to the core only after a successful load and holds it stable. Until a key has been accepted, the key bus is driven to all zeros, so the core stays locked.

## Interface
- `KEY_W`, default 37: key width. Bits [3:0] map to p1..p4; bits [36:4] map to X_1..X_33.
- `CNT_W`, default 6: bit-counter width. Must satisfy 2^CNT_W > KEY_W.

Ports:
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `load_start` input, 1 bit: starts a new load. Accepted only in IDLE.
- `load_abort` input, 1 bit: cancels an in-progress load.
- `key_sin` input, 1 bit: serial key data.
- `key_sin_valid` input, 1 bit: `key_sin` is consumed on any cycle where this is 1 and the state is SHIFT or PARITY.
- `key_out` output, KEY_W bits: committed key, connected to the core key pins.
- `key_valid` output, 1 bit: `key_out` holds a parity-checked key.
- `load_busy` output, 1 bit: 1 in SHIFT and PARITY.
- `load_err` output, 1 bit: sticky; the last load failed parity.
- `locked_out` output, 1 bit: lockout is active (see Configuration).

## Operation
- States: IDLE, SHIFT, PARITY, LOCKED.
- IDLE with `load_start`=1:
  - go to SHIFT;
  - bit counter ← 0;
  - `key_out` ← 0, `key_valid` ← 0, `load_err` ← 0.
- SHIFT, on each valid beat:
  - shift register ← {shreg[KEY_W-2:0], key_sin}, so the first bit received ends up in bit KEY_W-1 (MSB first);
  - counter increments;
  - the beat with counter == KEY_W-1 moves to PARITY.
- PARITY, on a valid beat:
  - if (^shreg) ^ key_sin == 0 (even parity): `key_out` ← shreg, `key_valid` ← 1;
  - otherwise: `load_err` ← 1 and `key_out` stays 0;
  - either way, return to IDLE.
- Beats with `key_sin_valid`=0 leave state and counter unchanged. There is no timeout.
- `load_abort` in SHIFT or PARITY:
  - return to IDLE;
  - shift register and counter cleared;
  - `key_out`=0, `key_valid`=0, `load_err` unchanged.
- Priority: `load_abort` > valid beat. `load_start` is ignored outside IDLE.
- `load_start` and `load_abort` asserted together in IDLE: `load_start` wins, since abort has no effect in IDLE.
- The shift register is never visible on `key_out` before commit.
- Reset mid-load: every register returns to its reset value immediately. No partial key is ever exposed.

## Timing
- Reset values: state IDLE, `key_out`=0, `key_valid`=0, `load_busy`=0, `load_err`=0, `locked_out`=0; shift register, counter and fail counter are 0.
- All outputs are registered.
- `load_busy` rises the cycle after `load_start` is accepted.
- A minimum load takes KEY_W+1 valid beats. `key_valid`/`load_err` update one edge after the parity beat, in the same edge that `load_busy` falls.
- Minimum back-to-back period: 1 (start) + KEY_W + 1 cycles. A new `load_start` is accepted the cycle after `load_busy` falls.

## Configuration
- `C499_KEY_LOCKOUT_EN` defined:
  - a 2-bit fail counter increments on each parity failure and clears on a successful commit;
  - the third consecutive failure enters LOCKED: `locked_out`=1, `key_out`=0, `load_start` ignored;
  - LOCKED exits only through `rst_n`.
- `C499_KEY_LOCKOUT_EN` undefined: no fail counter and no LOCKED state; `locked_out` is tied to 0; unlimited retries.

## Test plan
- Reset, then idle for 10 cycles: all outputs 0.
- Load key 37'h0_1234_5678 MSB first, parity bit = ^key = 1: `key_valid`=1 and `key_out`=37'h0_1234_5678 on the edge after the 38th beat; `load_busy` low in that same cycle.
- Same key with parity bit 0: `load_err`=1, `key_valid`=0, `key_out`=0; a following correct load clears `load_err` at start and commits.
- Abort after 20 beats, then a full valid load of 37'h1F_FFFF_FFFF (parity 1): the aborted bits do not leak; the commit equals 37'h1F_FFFF_FFFF.
- Beats interleaved with random `key_sin_valid`=0 gaps, plus `load_start` pulses mid-load: result identical to the gap-free load; the mid-load starts are ignored.
- Lockout test (with `C499_KEY_LOCKOUT_EN`): three consecutive bad-parity loads give `locked_out`=1, and a fourth `load_start` is ignored. Asserting `rst_n`=0 for one cycle clears everything. Without the macro, the fourth load commits normally.
